lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised successor to the fixed-polynomial LFSR.

- Width is set at elaboration; taps, seed and feedback mode (Fibonacci-XNOR or Galois-XOR) are programmable at run time.
- Adds a word-packing output with valid/ready backpressure, lock-up detection with automatic recovery, and a period counter that reports sequence length back to the seed.
- Sits between test/pattern logic and its pseudo-random consumers (LED demo, memory scrubbers, BIST).

## Interface
- NUM_BITS, 32, register width; legal range 3..32.
- OUT_BITS, 8, bits per output word; legal range 1..NUM_BITS.
- DEFAULT_TAPS, 32'h80200003, reset tap mask; bit k set means stage k+1 is tapped. Truncated to NUM_BITS.
- i_Clk  in  1  the single clock; all state changes on its rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Enable  in  1  allows stepping.
- i_Seed_DV  in  1  load seed this cycle.
- i_Seed_Data  in  NUM_BITS  seed value.
- i_Taps_DV  in  1  load taps and mode this cycle.
- i_Taps  in  NUM_BITS  tap mask.
- i_Mode  in  1  0 = Fibonacci XNOR, 1 = Galois XOR; sampled only on i_Taps_DV.
- i_Word_Ready  in  1  consumer accepts o_Word.
- o_Word  out  OUT_BITS  packed output word.
- o_Word_DV  out  1  o_Word valid.
- o_LFSR_Data  out  NUM_BITS  current state S.
- o_Period_Done  out  1  one-cycle pulse when S returns to the latched seed.
- o_Period_Count  out  NUM_BITS  steps in the last completed period; saturates at all-ones.
- o_Lockup  out  1  sticky lock-up flag.

## Operation
- **Registers:** S, seed R, taps T, mode M, accumulator A with bit counter C, step counter P.
- **Reset values:** S = R = 1; T = DEFAULT_TAPS; M = 0; o_Word = 0; o_Word_DV = 0; o_Period_Done = 0; o_Period_Count = 0; o_Lockup = 0; A = 0; C = 0; P = 0.
- **Step condition:** step = i_Enable & ~(o_Word_DV & ~i_Word_Ready) & ~i_Seed_DV & ~i_Taps_DV.
- **Output bit:** each step emits b = S[NUM_BITS-1], taken before the update.
- **Fibonacci (M = 0):** fb = ~^(S & T); S <= {S[NUM_BITS-2:0], fb}. Lock-up value is all-ones.
- **Galois (M = 1):** S <= {S[NUM_BITS-2:0], 1'b0} ^ (b ? T : 0). Lock-up value is 0.
- **Lock-up recovery:** if a step occurs while S equals the lock-up value for M:
  - S <= 1 instead of the normal update;
  - o_Lockup <= 1;
  - no bit is emitted;
  - P is cleared.
- **Word packing:** on each emitting step, A <= {A, b} and C increments.
  - On the step where C = OUT_BITS-1: o_Word <= {A[OUT_BITS-2:0], b}, o_Word_DV <= 1, C <= 0.
  - o_Word_DV clears when i_Word_Ready is high and no new word completes in the same cycle.
  - A completion in the same cycle as an accept replaces the word, and o_Word_DV stays 1.
- **Period counting:** on each normal step P increments.
  - If the next S equals R: o_Period_Count <= sat(P+1), o_Period_Done pulses for one cycle, P <= 0.
- **i_Seed_DV (no step this cycle):**
  - S <= i_Seed_Data, R <= i_Seed_Data;
  - A, C, P cleared;
  - o_Word_DV <= 0, o_Lockup <= 0.
- **i_Taps_DV (no step this cycle):**
  - T <= i_Taps, M <= i_Mode;
  - P cleared;
  - S, A, C and o_Word_DV unchanged.
- **Seed and taps in the same cycle:** both are applied.
- **i_Rst_n low:** returns every register to its reset value immediately, including mid-word and mid-period.

## Timing
- **Output registers:** all outputs come straight from registers; there are no combinational paths from inputs to outputs.
- **State visibility:** o_LFSR_Data shows the new state one cycle after the stepping edge.
- **First word latency:** after a seed load with continuous enable and ready, o_Word_DV first rises OUT_BITS+1 cycles after the i_Seed_DV cycle.
- **Sustained word rate:** one word every OUT_BITS cycles.
- **Backpressure:**
  - While o_Word_DV = 1 and i_Word_Ready = 0, S, A, C and P are frozen and o_Word is stable.
  - Stepping resumes in the accept cycle.
- **Period pulse:** o_Period_Done is asserted for exactly one cycle, coincident with the update of o_Period_Count.
- **Enable:** i_Enable low freezes S, A, C and P. o_Word_DV and the handshake still operate.

## Test plan
- **Fibonacci sequence and packing:** NUM_BITS=4, OUT_BITS=4, taps 4'b1100, mode 0, seed 4'h0, ready high.
  - First word 4'h0 with S = 4'hE; second word 4'hE with S = 4'hC.
  - After 15 steps, o_Period_Done pulses and o_Period_Count = 15.
- **Galois period:** NUM_BITS=4, taps 4'b0011, mode 1, seed 4'h1.
  - Sequence 1, 2, 4, 8, 3, …; o_Period_Count = 15 after 15 steps.
- **Lock-up recovery:** mode 0, NUM_BITS=4, seed 4'hF, enable.
  - Next cycle: o_Lockup = 1 and S = 4'h1.
  - A new i_Seed_DV clears o_Lockup.
- **Backpressure:** OUT_BITS=4, i_Word_Ready held low for 10 cycles after o_Word_DV rises.
  - o_LFSR_Data, o_Word and o_Word_DV remain constant throughout.
  - Releasing ready produces the next word exactly 4 cycles after the accept cycle.
- **Reset mid-word:** assert i_Rst_n low for 1 cycle after 2 steps.
  - All outputs are at reset values while low; S = 1, T = DEFAULT_TAPS.
- **Simultaneous loads:** i_Seed_DV and i_Taps_DV pulsed together with i_Enable high.
  - Both are applied, no step occurs that cycle, and stepping resumes the next cycle.

Source files
------------

// File: rtl/lfsr_gen.sv
// Run-time programmable LFSR with Fibonacci-XNOR or Galois-XOR feedback, word
// packing with valid/ready, lock-up recovery and period measurement.
module lfsr_gen #(
  parameter int          NUM_BITS     = 32,
  parameter int          OUT_BITS     = 8,
  parameter logic [31:0] DEFAULT_TAPS = 32'h80200003
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  input  logic                i_Taps_DV,
  input  logic [NUM_BITS-1:0] i_Taps,
  input  logic                i_Mode,
  input  logic                i_Word_Ready,
  output logic [OUT_BITS-1:0] o_Word,
  output logic                o_Word_DV,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_Period_Done,
  output logic [NUM_BITS-1:0] o_Period_Count,
  output logic                o_Lockup
);

  localparam int                CW    = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
  localparam logic [CW-1:0]     LAST  = CW'(OUT_BITS - 1);
  localparam logic [NUM_BITS-1:0] ONES = '1;
  localparam logic [NUM_BITS-1:0] ONE  = NUM_BITS'(1);

  logic [NUM_BITS-1:0] lfsr_q, lfsr_d;
  logic [NUM_BITS-1:0] seed_q, seed_d;
  logic [NUM_BITS-1:0] taps_q, taps_d;
  logic                mode_q, mode_d;
  logic [OUT_BITS-1:0] acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_BITS-1:0] per_q, per_d;
  logic [OUT_BITS-1:0] word_q, word_d;
  logic                word_dv_q, word_dv_d;
  logic                done_q, done_d;
  logic [NUM_BITS-1:0] per_cnt_q, per_cnt_d;
  logic                lock_q, lock_d;

  logic                step, bit_out, locked, fib_fb, complete;
  logic [NUM_BITS-1:0] shifted, lfsr_next, per_inc;
  logic [OUT_BITS:0]   pack;

  assign step      = i_Enable & ~(word_dv_q & ~i_Word_Ready) & ~i_Seed_DV & ~i_Taps_DV;
  assign bit_out   = lfsr_q[NUM_BITS-1];
  assign locked    = mode_q ? (lfsr_q == '0) : (lfsr_q == ONES);
  assign fib_fb    = ~^(lfsr_q & taps_q);
  assign shifted   = {lfsr_q[NUM_BITS-2:0], 1'b0};
  assign lfsr_next = mode_q ? (shifted ^ (bit_out ? taps_q : '0))
                            : {lfsr_q[NUM_BITS-2:0], fib_fb};
  assign per_inc   = (per_q == ONES) ? ONES : per_q + ONE;
  // Working with {A, b} keeps OUT_BITS == 1 legal without a special case.
  assign pack      = {acc_q, bit_out};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    lfsr_d    = lfsr_q;
    seed_d    = seed_q;
    taps_d    = taps_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    word_d    = word_q;
    done_d    = 1'b0;
    per_cnt_d = per_cnt_q;
    lock_d    = lock_q;
    complete  = 1'b0;

    if (step) begin
      if (locked) begin
        lfsr_d = ONE;
        lock_d = 1'b1;
        per_d  = '0;
      end else begin
        lfsr_d = lfsr_next;
        acc_d  = pack[OUT_BITS-1:0];
        if (cnt_q == LAST) begin
          word_d   = pack[OUT_BITS-1:0];
          cnt_d    = '0;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (lfsr_next == seed_q) begin
          per_cnt_d = per_inc;
          done_d    = 1'b1;
          per_d     = '0;
        end else begin
          per_d = per_inc;
        end
      end
    end

    if (i_Seed_DV) begin
      lfsr_d = i_Seed_Data;
      seed_d = i_Seed_Data;
      acc_d  = '0;
      cnt_d  = '0;
      per_d  = '0;
      lock_d = 1'b0;
    end
    if (i_Taps_DV) begin
      taps_d = i_Taps;
      mode_d = i_Mode;
      per_d  = '0;
    end

    if (i_Seed_DV)          word_dv_d = 1'b0;
    else if (complete)      word_dv_d = 1'b1;
    else if (i_Word_Ready)  word_dv_d = 1'b0;
    else                    word_dv_d = word_dv_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      lfsr_q    <= ONE;
      seed_q    <= ONE;
      taps_q    <= DEFAULT_TAPS[NUM_BITS-1:0];
      mode_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      per_q     <= '0;
      word_q    <= '0;
      word_dv_q <= 1'b0;
      done_q    <= 1'b0;
      per_cnt_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      lfsr_q    <= lfsr_d;
      seed_q    <= seed_d;
      taps_q    <= taps_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      word_q    <= word_d;
      word_dv_q <= word_dv_d;
      done_q    <= done_d;
      per_cnt_q <= per_cnt_d;
      lock_q    <= lock_d;
    end
  end

  assign o_Word         = word_q;
  assign o_Word_DV      = word_dv_q;
  assign o_LFSR_Data    = lfsr_q;
  assign o_Period_Done  = done_q;
  assign o_Period_Count = per_cnt_q;
  assign o_Lockup       = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed and random stimulus for lfsr_gen (4-bit state, 4-bit words) against
// a bit-queue reference model of the sequence, packing and period rules.
module tb_lfsr_gen;

  localparam int N    = 4;
  localparam int OB   = 4;
  localparam int MASK = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, sdv, tdv, md, rdy;
  logic [N-1:0]  sd, tp;
  logic [OB-1:0] word;
  logic          word_dv, pdone, lock;
  logic [N-1:0]  lfsr, pcnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int unsigned m_s, m_r, m_t, m_word, m_cnt;
  int          m_p;
  bit          m_m, m_dv, m_done, m_lock;
  bit          bits[$];

  lfsr_gen #(.NUM_BITS(N), .OUT_BITS(OB)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en),
    .i_Seed_DV(sdv), .i_Seed_Data(sd), .i_Taps_DV(tdv), .i_Taps(tp), .i_Mode(md),
    .i_Word_Ready(rdy), .o_Word(word), .o_Word_DV(word_dv), .o_LFSR_Data(lfsr),
    .o_Period_Done(pdone), .o_Period_Count(pcnt), .o_Lockup(lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s = 1; m_r = 1; m_t = 32'h80200003 & MASK; m_m = 0;
    m_word = 0; m_dv = 0; m_done = 0; m_cnt = 0; m_lock = 0; m_p = 0;
    bits.delete();
  endtask

  // Applies the behavioural rules for one rising edge using the driven inputs.
  task automatic model_edge();
    bit step, b, completed;
    int unsigned nxt, w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    step = en && !(m_dv && !rdy) && !sdv && !tdv;
    m_done = 0;
    completed = 0;
    if (step) begin
      if (m_s == (m_m ? 0 : MASK)) begin
        m_s = 1; m_lock = 1; m_p = 0;
      end else begin
        b = m_s[N-1];
        if (!m_m) nxt = ((m_s * 2) % (MASK + 1)) + (($countones(m_s & m_t) % 2 == 0) ? 1 : 0);
        else      nxt = ((m_s * 2) % (MASK + 1)) ^ (b ? m_t : 0);
        bits.push_back(b);
        if (bits.size() == OB) begin
          w = 0;
          foreach (bits[i]) w = w * 2 + bits[i];
          m_word = w;
          bits.delete();
          completed = 1;
        end
        m_p++;
        if (nxt == m_r) begin
          m_cnt = (m_p > MASK) ? MASK : m_p;
          m_done = 1;
          m_p = 0;
        end
        m_s = nxt;
      end
    end
    if (sdv) begin
      m_s = sd; m_r = sd; m_p = 0; m_lock = 0;
      bits.delete();
    end
    if (tdv) begin
      m_t = tp; m_m = md; m_p = 0;
    end
    if (sdv)            m_dv = 0;
    else if (completed) m_dv = 1;
    else if (rdy)       m_dv = 0;
  endtask

  task automatic check_all();
    check("word", word, m_word);
    check("word_dv", word_dv, m_dv);
    check("lfsr", lfsr, m_s);
    check("period_done", pdone, m_done);
    check("period_count", pcnt, m_cnt);
    check("lockup", lock, m_lock);
  endtask

  task automatic cycle(input bit e, input bit r, input bit s, input logic [N-1:0] sv,
                       input bit t, input logic [N-1:0] tv, input bit m);
    en = e; rdy = r; sdv = s; sd = sv; tdv = t; tp = tv; md = m;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(1, r, 0, '0, 0, '0, 0);
  endtask

  initial begin
    int n;
    logic [N-1:0] gal_seq [5];
    gal_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};

    rst_n = 0; en = 0; sdv = 0; tdv = 0; md = 0; rdy = 0; sd = '0; tp = '0;
    model_reset();
    #12;
    check_all();
    check("reset_lfsr", lfsr, 1);
    @(posedge clk); #1;
    rst_n = 1;

    // Fibonacci: taps 1100 and seed 0 loaded together while enabled
    cycle(1, 1, 1, 4'h0, 1, 4'b1100, 0);
    check("sim_load_no_step", lfsr, 4'h0);
    run(4, 1);
    check("fib_word1", word, 4'h0);
    check("fib_word1_dv", word_dv, 1);
    check("fib_s1", lfsr, 4'hE);
    run(4, 1);
    check("fib_word2", word, 4'hE);
    check("fib_s2", lfsr, 4'hC);
    run(7, 1);
    check("fib_period_done", pdone, 1);
    check("fib_period_count", pcnt, 15);
    run(3, 1);

    // Galois: taps and seed in separate cycles
    cycle(0, 1, 0, '0, 1, 4'b0011, 1);
    cycle(0, 1, 1, 4'h1, 0, '0, 0);
    check("gal_seq0", lfsr, gal_seq[0]);
    for (int i = 1; i < 5; i++) begin
      cycle(1, 1, 0, '0, 0, '0, 0);
      check("gal_seq", lfsr, gal_seq[i]);
    end
    run(11, 1);
    check("gal_period_done", pdone, 1);
    check("gal_period_count", pcnt, 15);

    // Lock-up recovery in Fibonacci mode
    cycle(0, 1, 1, 4'hF, 1, 4'b1100, 0);
    cycle(1, 1, 0, '0, 0, '0, 0);
    check("lockup_flag", lock, 1);
    check("lockup_state", lfsr, 1);
    run(3, 1);
    check("lockup_sticky", lock, 1);
    cycle(0, 1, 1, 4'h9, 0, '0, 0);
    check("lockup_clear", lock, 0);

    // Backpressure: hold ready low once a word is pending
    n = 0;
    while (!word_dv && n < 40) begin
      cycle(1, 0, 0, '0, 0, '0, 0);
      n++;
    end
    check("bp_word_timeout", word_dv, 1);
    run(10, 0);
    check("bp_hold_dv", word_dv, 1);
    cycle(1, 1, 0, '0, 0, '0, 0);
    n = 1;
    while (!word_dv && n < 20) begin
      cycle(1, 1, 0, '0, 0, '0, 0);
      n++;
    end
    check("bp_next_word_latency", n, 4);

    // Reset mid-word
    cycle(0, 1, 1, 4'h5, 0, '0, 0);
    run(2, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    rst_n = 1;
    cycle(1, 1, 0, '0, 0, '0, 0);
    check("post_reset_default_taps", lfsr, 4'h2);
    run(20, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 8) != 0, ($urandom % 3) != 0,
            ($urandom % 40) == 0, N'($urandom),
            ($urandom % 50) == 0, N'($urandom), $urandom % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
